pipeline_wb_capture: RTL and testbench
======================================

Name: pipeline_wb_capture

Overview:
- Consumer end of the EXE/WB result bus of the 4-stage pipelined register-file datapath.
- Accepts one writeback result per cycle and commits it to a 32x32 architectural register file.
- Exposes two combinational read ports with write-through bypass.
- Buffers every committed result in a trace FIFO, drained by a valid/ready consumer such as the bench or a debug port.

Parameters:
- FIFO_DEPTH, 8, trace FIFO entries; power of two, 2..64.
- DATA_W, 32, writeback data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wb_valid  input  1  EXE/WB result valid this cycle.
- wb_rd  input  5  destination register index.
- aluout_EXE_WB  input  DATA_W  writeback data.
- rs1_addr  input  5  read port 1 index.
- rs1_data  output  DATA_W  read port 1 data.
- rs2_addr  input  5  read port 2 index.
- rs2_data  output  DATA_W  read port 2 data.
- trc_valid  output  1  trace FIFO head valid.
- trc_ready  input  1  consumer accepts head.
- trc_rd  output  5  head destination index.
- trc_data  output  DATA_W  head data.
- trc_count  output  $clog2(FIFO_DEPTH)+1  occupancy.
- overflow  output  1  sticky; a commit was dropped from the trace.
- sig_out  output  DATA_W  running result signature (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - All 32 registers = 0.
  - FIFO empty: read and write pointers = 0, trc_count = 0, trc_valid = 0.
  - overflow = 0, sig_out = 0.
- Commit condition: wb_valid = 1 and wb_rd != 0.
- Register file write: on a commit, regs[wb_rd] <= aluout_EXE_WB at the rising edge.
- Register 0: always reads 0; writes to it are ignored and produce no trace entry.
- Read ports are combinational:
  - rsN_addr == 0 -> rsN_data = 0.
  - Else if a commit is in progress and wb_rd == rsN_addr -> rsN_data = aluout_EXE_WB (same-cycle bypass).
  - Else -> rsN_data = regs[rsN_addr].
- Trace FIFO push: every commit pushes {wb_rd, aluout_EXE_WB}.
- Trace FIFO pop: occurs when trc_valid & trc_ready.
- FIFO head: trc_rd and trc_data are driven straight from head storage. Latency from commit edge to trc_valid = 1 is one cycle.
- trc_count update: +1 on push only, -1 on pop only, unchanged when both occur in the same cycle.
- Full FIFO with a push and no pop in the same cycle:
  - Entry dropped; overflow <= 1.
  - Register file write still happens.
- Full FIFO with a push and a pop in the same cycle: both occur, count stays FIFO_DEPTH, no overflow.
- Empty FIFO with a push and trc_ready = 1: no pop that cycle because trc_valid = 0; the entry appears next cycle.
- Pointers wrap modulo FIFO_DEPTH.
- overflow clears only on rst.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight commits are lost.

Optional Feature:
- Macro: WB_SIGNATURE_EN.
- Defined:
  - On each commit, sig_out <= {sig_out[DATA_W-2:0], sig_out[DATA_W-1]} ^ aluout_EXE_WB.
  - Dropped (overflow) commits still update the signature.
  - Reset value is 0.
- Undefined: sig_out tied to 0; no signature register is synthesized.

Test Plan:
- Reset then idle: rst pulse, check trc_valid = 0, trc_count = 0, overflow = 0, rs1_data = rs2_data = 0 for addresses 0..31.
- Commit and bypass: wb_valid = 1, wb_rd = 5, data = 0xDEADBEEF with rs1_addr = 5 -> rs1_data = 0xDEADBEEF in the same cycle. Next cycle (wb_valid = 0), rs1_data = 0xDEADBEEF and trc_valid = 1, trc_rd = 5, trc_data = 0xDEADBEEF.
- Register 0: commit wb_rd = 0, data = 0x1234 -> rs1_data for addr 0 stays 0; trc_count unchanged.
- Fill and overflow: trc_ready = 0, 9 commits to r1..r9 with data 1..9, FIFO_DEPTH = 8:
  - Check trc_count = 8, overflow = 1, regs[9] = 9.
  - Drain yields data 1..8 in order, then trc_valid = 0.
- Full with simultaneous push/pop: FIFO full and trc_ready = 1, commit data 0xA5 -> count stays 8, overflow stays 0, 0xA5 emerges last.
- Signature (WB_SIGNATURE_EN defined): commits 0x1 then 0x2 -> sig_out = 0x1, then 0x0 (0x2 ^ 0x2). Assert rst mid-stream -> sig_out = 0 and FIFO empty.

Source files
------------

// File: rtl/pipeline_wb_capture_if.sv
// -----------------------------------------------------------------------------
// pipeline_wb_capture_if
// EXE/WB result bus, register read ports and trace drain port of the
// writeback capture block.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface pipeline_wb_capture_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 32
);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                wb_valid;
  logic [4:0]          wb_rd;
  logic [DATA_W-1:0]   aluout_EXE_WB;
  logic [4:0]          rs1_addr;
  logic [DATA_W-1:0]   rs1_data;
  logic [4:0]          rs2_addr;
  logic [DATA_W-1:0]   rs2_data;
  logic                trc_valid;
  logic                trc_ready;
  logic [4:0]          trc_rd;
  logic [DATA_W-1:0]   trc_data;
  logic [c_CNT_W-1:0]  trc_count;
  logic                overflow;
  logic [DATA_W-1:0]   sig_out;

  modport master (
    output wb_valid, wb_rd, aluout_EXE_WB, rs1_addr, rs2_addr, trc_ready,
    input  rs1_data, rs2_data, trc_valid, trc_rd, trc_data, trc_count,
           overflow, sig_out
  );

  modport slave (
    input  wb_valid, wb_rd, aluout_EXE_WB, rs1_addr, rs2_addr, trc_ready,
    output rs1_data, rs2_data, trc_valid, trc_rd, trc_data, trc_count,
           overflow, sig_out
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_wb_capture.sv
// -----------------------------------------------------------------------------
// pipeline_wb_capture
// Commits EXE/WB results into a 32x32 register file with bypassed read ports
// and records every commit in a trace FIFO. Optional macro WB_SIGNATURE_EN
// enables a rotate-xor running signature of committed data on sig_out.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pipeline_wb_capture #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  pipeline_wb_capture_if.slave bus
);

  localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0]  r_regs      [32];
  logic [4:0]         r_fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;

  logic w_commit;
  logic w_full;
  logic w_valid;
  logic w_pop;
  logic w_push;

  assign w_commit = bus.wb_valid && (bus.wb_rd != 5'd0);
  assign w_full   = (r_count == c_DEPTH);
  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid && bus.trc_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push   = w_commit && (!w_full || w_pop);

  // Register file; entry 0 is never written and never read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[bus.wb_rd] <= bus.aluout_EXE_WB;
    end
  end

  assign bus.rs1_data = (bus.rs1_addr == 5'd0)                  ? '0 :
                        (w_commit && bus.wb_rd == bus.rs1_addr) ? bus.aluout_EXE_WB :
                                                                  r_regs[bus.rs1_addr];
  assign bus.rs2_data = (bus.rs2_addr == 5'd0)                  ? '0 :
                        (w_commit && bus.wb_rd == bus.rs2_addr) ? bus.aluout_EXE_WB :
                                                                  r_regs[bus.rs2_addr];

  // Trace storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= bus.wb_rd;
      r_fifo_data[r_wr_ptr] <= bus.aluout_EXE_WB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_commit && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.trc_valid = w_valid;
  assign bus.trc_rd    = r_fifo_rd[r_rd_ptr];
  assign bus.trc_data  = r_fifo_data[r_rd_ptr];
  assign bus.trc_count = r_count;
  assign bus.overflow  = r_overflow;

`ifdef WB_SIGNATURE_EN
  logic [DATA_W-1:0] r_sig;

  // Dropped commits still fold into the signature.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
    end else if (w_commit) begin
      r_sig <= {r_sig[DATA_W-2:0], r_sig[DATA_W-1]} ^ bus.aluout_EXE_WB;
    end
  end

  assign bus.sig_out = r_sig;
`else
  assign bus.sig_out = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_wb_capture.sv
// Self-checking bench for pipeline_wb_capture: a reference model predicts read
// ports and status, and a scoreboard queue holds expected trace entries.
`default_nettype none

module tb_pipeline_wb_capture;

  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_wb_capture_if #(.FIFO_DEPTH(DEPTH), .DATA_W(DW)) bus ();

  pipeline_wb_capture #(.FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [36:0] sb_q [$];
  logic [31:0] m_regs [32];
  logic        m_ovf;
  logic [31:0] m_sig;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_ovf = 1'b0;
    m_sig = '0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic commit,
                                           input logic [4:0] rd, input logic [31:0] d);
    if (a == 5'd0) return '0;
    if (commit && rd == a) return d;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_sig();
`ifdef WB_SIGNATURE_EN
    return m_sig;
`else
    return '0;
`endif
  endfunction

  // One clock: drive at negedge, check combinational paths, update model, check state after posedge.
  task automatic cycle(input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic rdy, input logic [4:0] a1, input logic [4:0] a2);
    logic        commit;
    logic        pop;
    logic [36:0] head;
    @(negedge clk);
    bus.wb_valid      = v;
    bus.wb_rd         = rd;
    bus.aluout_EXE_WB = d;
    bus.trc_ready     = rdy;
    bus.rs1_addr      = a1;
    bus.rs2_addr      = a2;
    #1;
    commit = v && (rd != 5'd0);
    check("rs1_data", bus.rs1_data, exp_read(a1, commit, rd, d));
    check("rs2_data", bus.rs2_data, exp_read(a2, commit, rd, d));
    check("trc_valid", bus.trc_valid, sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      head = sb_q[0];
      check("trc_rd", bus.trc_rd, head[36:32]);
      check("trc_data", bus.trc_data, head[31:0]);
    end
    pop = (sb_q.size() != 0) && rdy;
    if (pop) void'(sb_q.pop_front());
    if (commit) begin
      if (sb_q.size() == DEPTH) m_ovf = 1'b1;
      else sb_q.push_back({rd, d});
      m_regs[rd] = d;
      m_sig = {m_sig[30:0], m_sig[31]} ^ d;
    end
    @(posedge clk);
    #1;
    check("trc_count", bus.trc_count, sb_q.size());
    check("overflow", bus.overflow, m_ovf);
    check("sig_out", bus.sig_out, exp_sig());
  endtask

  task automatic idle(input logic rdy, input logic [4:0] a1, input logic [4:0] a2);
    cycle(1'b0, 5'd0, 32'd0, rdy, a1, a2);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.wb_valid = 1'b0;
    #1;
    check("rst_count", bus.trc_count, 0);
    check("rst_valid", bus.trc_valid, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_sig", bus.sig_out, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.wb_valid      = 1'b0;
    bus.wb_rd         = '0;
    bus.aluout_EXE_WB = '0;
    bus.trc_ready     = 1'b0;
    bus.rs1_addr      = '0;
    bus.rs2_addr      = '0;
    model_reset();

    // Reset then idle: every register reads zero.
    apply_reset();
    for (int i = 0; i < 32; i++) idle(1'b0, 5'(i), 5'(31 - i));

    // Commit with same-cycle bypass, then visible in register and trace.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
    check("bypass_rs1", bus.rs1_data, 32'hDEADBEEF);
    idle(1'b0, 5'd5, 5'd5);
    check("trace_rd5", bus.trc_rd, 5'd5);
    check("trace_data5", bus.trc_data, 32'hDEADBEEF);
    idle(1'b1, 5'd5, 5'd0);

    // Register 0 writes are ignored and untraced.
    cycle(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0);
    check("r0_count", bus.trc_count, 0);
    idle(1'b0, 5'd0, 5'd0);

    // Fill and overflow.
    for (int i = 1; i <= 9; i++) cycle(1'b1, 5'(i), 32'(i), 1'b0, 5'(i), 5'd0);
    check("fill_count", bus.trc_count, 8);
    check("fill_ovf", bus.overflow, 1);
    idle(1'b0, 5'd9, 5'd1);
    check("reg9", bus.rs1_data, 32'd9);
    for (int i = 0; i < 9; i++) idle(1'b1, 5'd0, 5'd0);
    check("drained", bus.trc_valid, 0);

    // Full with simultaneous push and pop.
    apply_reset();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 5'(i + 10), 32'(i * 3), 1'b0, 5'd0, 5'd0);
    cycle(1'b1, 5'd20, 32'hA5, 1'b1, 5'd20, 5'd0);
    check("pp_count", bus.trc_count, 8);
    check("pp_ovf", bus.overflow, 0);
    for (int i = 0; i < 7; i++) idle(1'b1, 5'd0, 5'd0);
    check("pp_last", bus.trc_data, 32'hA5);
    idle(1'b1, 5'd0, 5'd0);
    idle(1'b1, 5'd0, 5'd0);

    // Signature sequence and mid-stream reset.
    apply_reset();
    cycle(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 5'd0);
`ifdef WB_SIGNATURE_EN
    check("sig_first", bus.sig_out, 32'h1);
`endif
    cycle(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 5'd0);
    check("sig_second", bus.sig_out, 32'h0);
    cycle(1'b1, 5'd3, 32'h77, 1'b0, 5'd3, 5'd0);
    @(negedge clk);
    bus.wb_valid      = 1'b1;
    bus.wb_rd         = 5'd7;
    bus.aluout_EXE_WB = 32'h55;
    #2;
    rst = 1'b1;
    #1;
    bus.wb_valid = 1'b0;
    bus.rs1_addr = 5'd3;
    #1;
    check("mid_count", bus.trc_count, 0);
    check("mid_valid", bus.trc_valid, 0);
    check("mid_sig", bus.sig_out, 0);
    check("mid_reg3", bus.rs1_data, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1, 5'd3, 5'd7);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1, 5'd0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
